// File: rtl/paralelo_serial_tx_pkg.sv
// Shared constants, state encoding and frame-selection payload for the serial transmit path.
package paralelo_serial_tx_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned CNT_W          = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] COM_CHAR_DEF = 8'hBC;
    localparam int unsigned SYNC_COUNT_DEF = 4;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic              is_data;
    } frame_sel_t;

    // Bit counter runs 7..0; the natural 3-bit underflow provides the wrap back to 7.
    function automatic logic [CNT_W-1:0] next_bit(input logic [CNT_W-1:0] cnt);
        return cnt - CNT_W'(1);
    endfunction

endpackage

// File: rtl/paralelo_serial_tx_hold.sv
// One-entry valid/ready hold register between the byte source and the frame serializer.
module paralelo_serial_tx_hold
    import paralelo_serial_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic [DATA_W-1:0] dout,
    output logic              ready
);

    logic              full_q,  full_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    // A drained entry only reopens the slot one cycle later: no same-edge bypass.
    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end
        ready_d = ~full_d & ~drain;
    end

    assign full  = full_q;
    assign dout  = data_q;
    assign ready = ready_q;

endmodule

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial link transmitter: MSB-first 8-bit frames, COM_CHAR sync/idle frames, one-entry input hold.
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [DATA_W-1:0] COM_CHAR   = COM_CHAR_DEF,
    parameter int unsigned       SYNC_COUNT = SYNC_COUNT_DEF
)
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              frame_start,
    output logic              data_frame,
    output logic              active
);

    localparam int unsigned SYNC_W = (SYNC_COUNT < 1) ? 1 : $clog2(SYNC_COUNT + 1);

    tx_state_e         state_q,       state_d;
    logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q,    sync_cnt_d;
    logic [DATA_W-1:0] shift_q,       shift_d;
    logic              data_out_q,    data_out_d;
    logic              frame_start_q, frame_start_d;
    logic              data_frame_q,  data_frame_d;
    logic              active_q,      active_d;

    logic              hold_load;
    logic              hold_drain;
    logic              hold_full;
    logic              hold_ready;
    logic [DATA_W-1:0] hold_data;
    logic              go_run;
    frame_sel_t        sel;

    assign hold_load = valid_in & hold_ready;

    paralelo_serial_tx_hold u_hold (
        .clk   (clk_32f),
        .rst_n (reset),
        .load  (hold_load),
        .drain (hold_drain),
        .din   (data_in),
        .full  (hold_full),
        .dout  (hold_data),
        .ready (hold_ready)
    );

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SYNC;
            bit_cnt_q     <= CNT_W'(DATA_W - 1);
            sync_cnt_q    <= '0;
            shift_q       <= '0;
            data_out_q    <= 1'b0;
            frame_start_q <= 1'b0;
            data_frame_q  <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sync_cnt_q    <= sync_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            frame_start_q <= frame_start_d;
            data_frame_q  <= data_frame_d;
            active_q      <= active_d;
        end
    end

    // bit_cnt_q names the bit driven on the coming edge; 7 marks a frame boundary where the next word is chosen.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = next_bit(bit_cnt_q);
        sync_cnt_d    = sync_cnt_q;
        shift_d       = shift_q;
        data_out_d    = shift_q[bit_cnt_q];
        frame_start_d = 1'b0;
        data_frame_d  = data_frame_q;
        active_d      = active_q;
        hold_drain    = 1'b0;
        go_run        = 1'b0;
        sel           = '{word: COM_CHAR, is_data: 1'b0};

        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            frame_start_d = 1'b1;
            if (state_q == ST_RUN) begin
                go_run = 1'b1;
            end else if (sync_cnt_q == SYNC_W'(SYNC_COUNT)) begin
                state_d = ST_RUN;
                go_run  = 1'b1;
            end else begin
                sync_cnt_d = sync_cnt_q + SYNC_W'(1);
            end

            if (go_run) begin
                active_d = 1'b1;
                if (hold_full) begin
                    hold_drain = 1'b1;
                    sel        = '{word: hold_data, is_data: 1'b1};
                end
            end

            shift_d      = sel.word;
            data_out_d   = sel.word[DATA_W-1];
            data_frame_d = sel.is_data;
        end
    end

    assign ready_out   = hold_ready;
    assign data_out    = data_out_q;
    assign frame_start = frame_start_q;
    assign data_frame  = data_frame_q;
    assign active      = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: cycle tables for sync/reset behaviour, scoreboard for streamed data.
module tb_paralelo_serial_tx;
    import paralelo_serial_tx_pkg::*;

    logic       clk_32f  = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, frame_start, data_frame, active;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam int SYNC_CYC = 8 * int'(SYNC_COUNT_DEF);

    always #5 clk_32f = ~clk_32f;
    always @(posedge clk_32f) cyc <= cyc + 1;

    paralelo_serial_tx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .frame_start (frame_start),
        .data_frame  (data_frame),
        .active      (active)
    );

    typedef struct {
        int         cyc;
        logic [7:0] din;
        logic       vin;
        logic       dout;
        logic       fs;
        logic       df;
        logic       act;
        logic       rdy;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         acc_cyc[$];
    int         data_frames[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected outputs from reset release: SYNC_COUNT COM frames, then one data frame if a word was offered.
    task automatic build_vecs(input int n, input logic [7:0] word, input int vin_cyc);
        vec_t       v;
        logic [7:0] w;
        int         f;
        int         b;
        bit         has;
        vecs.delete();
        for (int c = 0; c < n; c++) begin
            f     = c / 8;
            b     = 7 - (c % 8);
            has   = (vin_cyc >= 0) && (f == int'(SYNC_COUNT_DEF));
            w     = has ? word : 8'hBC;
            v.cyc = c;
            v.din = word;
            v.vin = (c == vin_cyc);
            v.dout = w[b];
            v.fs  = (c % 8 == 0);
            v.df  = has;
            v.act = (c >= SYNC_CYC);
            v.rdy = !((vin_cyc >= 0) && (c > vin_cyc) && (c <= SYNC_CYC));
            vecs.push_back(v);
        end
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk_32f);
            chk($sformatf("%s data_out c%0d", tag, vecs[i].cyc),    32'(data_out),    32'(vecs[i].dout));
            chk($sformatf("%s frame_start c%0d", tag, vecs[i].cyc), 32'(frame_start), 32'(vecs[i].fs));
            chk($sformatf("%s data_frame c%0d", tag, vecs[i].cyc),  32'(data_frame),  32'(vecs[i].df));
            chk($sformatf("%s active c%0d", tag, vecs[i].cyc),      32'(active),      32'(vecs[i].act));
            chk($sformatf("%s ready_out c%0d", tag, vecs[i].cyc),   32'(ready_out),   32'(vecs[i].rdy));
            data_in  = vecs[i].din;
            valid_in = vecs[i].vin;
        end
    endtask

    // Asserts reset, checks outputs clear immediately, releases at a falling edge.
    task automatic do_reset(input string tag);
        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        chk({tag, " rst data_out"},    32'(data_out),    32'd0);
        chk({tag, " rst frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, " rst data_frame"},  32'(data_frame),  32'd0);
        chk({tag, " rst active"},      32'(active),      32'd0);
        chk({tag, " rst ready_out"},   32'(ready_out),   32'd0);
        repeat (2) @(negedge clk_32f);
        sb.delete();
        reset = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_word(input logic [7:0] w);
        int k = 0;
        data_in  = w;
        valid_in = 1'b1;
        while (!ready_out && k < 64) begin
            @(negedge clk_32f);
            k++;
        end
        if (!ready_out) begin
            chk("send_word ready timeout", 32'(ready_out), 32'd1);
        end else begin
            sb.push_back(w);
            acc_cyc.push_back(cyc);
        end
        @(negedge clk_32f);
        valid_in = 1'b0;
    endtask

    // Frame monitor: reassembles frames, pops the scoreboard for data frames, expects COM otherwise.
    bit         mon_en     = 1'b0;
    bit         have_start = 1'b0;
    bit         df_bad     = 1'b0;
    logic       fdf        = 1'b0;
    logic [7:0] cur        = 8'h00;
    logic [7:0] exp_w;
    int         nb         = 0;
    int         frame_idx  = 0;

    always @(negedge clk_32f) begin
        if (!mon_en) begin
            have_start = 1'b0;
        end else begin
            if (frame_start) begin
                have_start = 1'b1;
                nb         = 0;
                cur        = 8'h00;
                fdf        = data_frame;
                df_bad     = 1'b0;
                frame_idx++;
            end
            if (have_start) begin
                cur = {cur[6:0], data_out};
                nb++;
                if (data_frame !== fdf) df_bad = 1'b1;
                if (nb == 8) begin
                    have_start = 1'b0;
                    chk("mon data_frame steady", 32'(df_bad), 32'd0);
                    if (fdf) begin
                        if (sb.size() == 0) begin
                            chk("mon unexpected data frame", 32'(cur), 32'hFFFF_FFFF);
                        end else begin
                            exp_w = sb.pop_front();
                            chk("mon data word", 32'(cur), 32'(exp_w));
                            data_frames.push_back(frame_idx);
                        end
                    end else begin
                        chk("mon com word", 32'(cur), 32'hBC);
                    end
                end
            end
        end
    end

    logic [7:0] words[$];

    initial begin
        int k;

        #2;
        do_reset("t1");
        build_vecs(48, 8'h5A, 2);
        run_vecs("sync+5A");

        words = '{8'h01, 8'h02, 8'h03, 8'hBC, 8'h00, 8'hFF};
        for (int i = 0; i < 6; i++) words.push_back(8'($urandom_range(0, 255)));
        acc_cyc.delete();
        data_frames.delete();
        mon_en = 1'b1;
        foreach (words[i]) send_word(words[i]);
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk_32f);
            k++;
        end
        chk("stream scoreboard drained", 32'(sb.size()), 32'd0);
        chk("stream data frame count", 32'(data_frames.size()), 32'(words.size()));
        for (int i = 1; i < data_frames.size(); i++)
            chk($sformatf("stream contiguous %0d", i), 32'(data_frames[i] - data_frames[i-1]), 32'd1);
        for (int i = 2; i < acc_cyc.size(); i++)
            chk($sformatf("stream accept spacing %0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd8);
        mon_en = 1'b0;
        repeat (3) @(negedge clk_32f);

        send_word(8'hF0);
        send_word(8'h33);
        chk("mid F0 data_frame", 32'(data_frame), 32'd1);
        @(negedge clk_32f);
        chk("mid F0 bit4", 32'(data_out), 32'd1);
        chk("mid hold full", 32'(ready_out), 32'd0);
        do_reset("t4");
        build_vecs(48, 8'h00, -1);
        run_vecs("after-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout: got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
